// File: rtl/serial_frame_tx_if.sv
// Bus between a frame source and serial_frame_tx: bit strobe, request and payload in,
// serial line and frame status out.
interface serial_frame_tx_if #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 16,
    parameter int PORT_W = 2
);
    logic              bit_en;
    logic              start;
    logic [PORT_W-1:0] port_num;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              ser_out;
    logic              busy;
    logic              ser_valid;
    logic              done;

    modport master (
        output bit_en, start, port_num, len, data,
        input  ser_out, busy, ser_valid, done
    );

    modport slave (
        input  bit_en, start, port_num, len, data,
        output ser_out, busy, ser_valid, done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serializes {start 0, port MSB-first, len MSB-first, payload LSB-first, stop 1}, one bit per bit_en.
// Optional even-parity bit before stop when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 16,
    parameter int PORT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    serial_frame_tx_if.slave bus
);
    localparam int CNT_W = (LEN_W > PORT_W) ? LEN_W : PORT_W;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PORT_W-1:0] port_sh_q, port_sh_d;
    logic [LEN_W-1:0]  len_sh_q, len_sh_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic              ser_out_q, ser_out_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic par_q, par_d;

    // Even parity over the low n payload bits only; bits above len-1 never go out.
    function automatic logic payload_parity(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i < int'(n)) p ^= d[i];
        return p;
    endfunction
`endif

    always_comb begin
        // NOTE: every next-value signal is defaulted first so no latch can be inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_sh_d = port_sh_q;
        len_sh_d  = len_sh_q;
        len_d     = len_q;
        data_sh_d = data_sh_q;
        ser_out_d = ser_out_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                ser_out_d = 1'b1;
                // A request during the done pulse is dropped; it is taken from the next cycle.
                if (bus.start && !done_q) begin
                    port_sh_d = bus.port_num;
                    len_sh_d  = bus.len;
                    len_d     = bus.len;
                    data_sh_d = bus.data;
                    busy_d    = 1'b1;
                    ser_out_d = 1'b0;
                    state_d   = S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d     = payload_parity(bus.data, bus.len);
`endif
                end
            end
            S_START: if (bus.bit_en) begin
                ser_out_d = port_sh_q[PORT_W-1];
                port_sh_d = port_sh_q << 1;
                cnt_d     = CNT_W'(PORT_W - 1);
                state_d   = S_PORT;
            end
            S_PORT: if (bus.bit_en) begin
                if (cnt_q == '0) begin
                    ser_out_d = len_sh_q[LEN_W-1];
                    len_sh_d  = len_sh_q << 1;
                    cnt_d     = CNT_W'(LEN_W - 1);
                    state_d   = S_LEN;
                end else begin
                    ser_out_d = port_sh_q[PORT_W-1];
                    port_sh_d = port_sh_q << 1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
            S_LEN: if (bus.bit_en) begin
                if (cnt_q != '0) begin
                    ser_out_d = len_sh_q[LEN_W-1];
                    len_sh_d  = len_sh_q << 1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else if (len_q == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    ser_out_d = par_q;
                    state_d   = S_PARITY;
`else
                    ser_out_d = 1'b1;
                    state_d   = S_STOP;
`endif
                end else begin
                    ser_out_d = data_sh_q[0];
                    data_sh_d = data_sh_q >> 1;
                    valid_d   = 1'b1;
                    cnt_d     = CNT_W'(len_q - LEN_W'(1));
                    state_d   = S_DATA;
                end
            end
            S_DATA: if (bus.bit_en) begin
                if (cnt_q == '0) begin
                    valid_d   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    ser_out_d = par_q;
                    state_d   = S_PARITY;
`else
                    ser_out_d = 1'b1;
                    state_d   = S_STOP;
`endif
                end else begin
                    ser_out_d = data_sh_q[0];
                    data_sh_d = data_sh_q >> 1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: if (bus.bit_en) begin
                ser_out_d = 1'b1;
                state_d   = S_STOP;
            end
`endif
            S_STOP: if (bus.bit_en) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                ser_out_d = 1'b1;
                busy_d    = 1'b0;
                valid_d   = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // NOTE: registered state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            port_sh_q <= '0;
            len_sh_q  <= '0;
            len_q     <= '0;
            data_sh_q <= '0;
            ser_out_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_sh_q <= port_sh_d;
            len_sh_q  <= len_sh_d;
            len_q     <= len_d;
            data_sh_q <= data_sh_d;
            ser_out_q <= ser_out_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.busy      = busy_q;
    assign bus.ser_valid = valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: queue-based frame model compared every cycle,
// plus literal bit sequences for the directed frames.
module tb_serial_frame_tx;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 16;
    localparam int PORT_W = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_frame_tx_if #(.LEN_W(LEN_W), .DATA_W(DATA_W), .PORT_W(PORT_W)) bus ();

    serial_frame_tx #(.LEN_W(LEN_W), .DATA_W(DATA_W), .PORT_W(PORT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame model: on accept, the whole frame is laid out as a bit list; each strobe pops one bit.
    logic m_ser = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0;
    bit   mq[$];
    bit   vq[$];

    always @(posedge clk or posedge rst) begin : model
        logic was_done;
        bit   pp;
        if (rst) begin
            m_ser = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
            mq.delete(); vq.delete();
        end else begin
            was_done = m_done;
            m_done   = 1'b0;
            if (!m_busy) begin
                if (bus.start && !was_done) begin
                    mq.delete(); vq.delete();
                    for (int i = PORT_W - 1; i >= 0; i--) begin mq.push_back(bus.port_num[i]); vq.push_back(1'b0); end
                    for (int i = LEN_W - 1; i >= 0; i--)  begin mq.push_back(bus.len[i]);      vq.push_back(1'b0); end
                    pp = 1'b0;
                    for (int i = 0; i < int'(bus.len); i++) begin
                        mq.push_back(bus.data[i]); vq.push_back(1'b1); pp ^= bus.data[i];
                    end
                    if (PAR_BITS == 1) begin mq.push_back(pp); vq.push_back(1'b0); end
                    mq.push_back(1'b1); vq.push_back(1'b0);
                    m_busy = 1'b1; m_ser = 1'b0; m_valid = 1'b0;
                end
            end else if (bus.bit_en) begin
                if (mq.size() == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_ser = 1'b1; m_valid = 1'b0;
                end else begin
                    m_ser   = mq.pop_front();
                    m_valid = vq.pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ser_out vs model",   bus.ser_out,   m_ser);
        check("busy vs model",      bus.busy,      m_busy);
        check("ser_valid vs model", bus.ser_valid, m_valid);
        check("done vs model",      bus.done,      m_done);
    end

    bit rec[$];
    int valid_cycles, busy_cycles, done_cycles;

    task automatic run_frame(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d, input int period);
        rec.delete(); valid_cycles = 0; busy_cycles = 0; done_cycles = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.port_num = p; bus.len = l; bus.data = d; bus.bit_en = (period == 1);
        for (int k = 1; k <= (PAR_BITS + 8 + int'(l)) * period + 4; k++) begin
            @(negedge clk);
            if (bus.busy) begin rec.push_back(bus.ser_out); busy_cycles++; end
            if (bus.ser_valid) valid_cycles++;
            if (bus.done) done_cycles++;
            bus.start = 1'b0; bus.bit_en = (k % period == 0);
            bus.port_num = ~p; bus.len = ~l; bus.data = ~d;
        end
        bus.bit_en = 1'b0;
    endtask

    task automatic check_seq(input string name, input logic [31:0] exp, input int nbits, input int period);
        logic [31:0] got;
        int          held_ok;
        got = '0;
        held_ok = 1;
        check({name, " length"}, rec.size(), nbits * period);
        if (rec.size() == nbits * period) begin
            for (int i = 0; i < nbits; i++) begin
                got[nbits-1-i] = rec[i*period];
                for (int j = 1; j < period; j++)
                    if (rec[i*period+j] != rec[i*period]) held_ok = 0;
            end
            check({name, " bits"}, got, exp);
            check({name, " held"}, held_ok, 1);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int got_done;
        bus.bit_en = 1'b0; bus.start = 1'b0; bus.port_num = '0; bus.len = '0; bus.data = '0;
        #50 rst = 1'b0;

        @(negedge clk);
        check("reset ser_out", bus.ser_out, 1);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset ser_valid", bus.ser_valid, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.bit_en = k[0];
        end
        check("idle busy", bus.busy, 0);
        check("idle ser_out", bus.ser_out, 1);

        // port 10, len 3, data 101 -> 0 10 0011 101 [parity 0] 1
        run_frame(2'b10, 4'd3, 16'h0005, 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        check_seq("frame1", 32'b010001110101, 12, 1);
`else
        check_seq("frame1", 32'b01000111011, 11, 1);
`endif
        check("frame1 valid cycles", valid_cycles, 3);
        check("frame1 busy cycles", busy_cycles, 11 + PAR_BITS);
        check("frame1 done pulses", done_cycles, 1);

        run_frame(2'b10, 4'd3, 16'h0005, 4);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        check_seq("frame1 slow", 32'b010001110101, 12, 4);
`else
        check_seq("frame1 slow", 32'b01000111011, 11, 4);
`endif
        check("frame1 slow valid cycles", valid_cycles, 12);
        check("frame1 slow done pulses", done_cycles, 1);

        // len 0: payload skipped
        run_frame(2'b01, 4'd0, 16'hFFFF, 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        check_seq("len0", 32'b001000001, 9, 1);
`else
        check_seq("len0", 32'b00100001, 8, 1);
`endif
        check("len0 valid cycles", valid_cycles, 0);
        check("len0 done pulses", done_cycles, 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
        run_frame(2'b10, 4'd3, 16'h0007, 1);
        check_seq("parity odd payload", 32'b010001111111, 12, 1);
`endif

        // Requests mid-frame, in the STOP cycle and in the done cycle are ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.port_num = 2'b11; bus.len = 4'd2; bus.data = 16'h0002; bus.bit_en = 1'b1;
        got_done = 0;
        for (int k = 1; k <= 40 && got_done == 0; k++) begin
            @(negedge clk);
            if (bus.done) got_done = 1;
            else bus.start = (k == 4 || k == 10 + PAR_BITS);
        end
        check("restart first done seen", got_done, 1);
        bus.start = 1'b1; bus.port_num = 2'b01; bus.len = 4'd1; bus.data = 16'h0001;
        @(negedge clk);
        check("done-cycle start ignored", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check("next-cycle start busy", bus.busy, 1);
        check("next-cycle start bit", bus.ser_out, 0);
        got_done = 0;
        for (int k = 0; k < 40 && got_done == 0; k++) begin
            @(negedge clk);
            if (bus.done) got_done = 1;
        end
        check("restart second done seen", got_done, 1);

        // Reset during DATA aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.port_num = 2'b10; bus.len = 4'd8; bus.data = 16'h00A5; bus.bit_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 20 && bus.ser_valid == 1'b0; k++) @(negedge clk);
        check("reached payload", bus.ser_valid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort ser_out", bus.ser_out, 1);
        check("abort busy", bus.busy, 0);
        check("abort ser_valid", bus.ser_valid, 0);
        check("abort done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) done_cycles++;
        end
        check("abort no done", done_cycles, 0);
        check("abort idle busy", bus.busy, 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Upstream frame serializer for the serial port-demultiplexer datapath (shift registers, port/data counters, controller, SSD).
- Accepts a port number, a payload length and a payload word in parallel.
- Emits the frame on a single serial line in the format the demux controller consumes: start 0, 2-bit port, 4-bit length, payload bits, stop 1.
- Bit timing is paced by a one-cycle bit-enable strobe, so it can run from a free clock or the push-button one-pulser.

Parameters:
- LEN_W, 4, width of the length field; the payload length ranges 0..2^LEN_W-1.
- DATA_W, 16, width of the payload input register; must be >= 2^LEN_W-1.
- PORT_W, 2, width of the port-number field.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_en  input  1  one-cycle strobe; each strobe advances the line by one bit.
- start  input  1  request to send a frame; sampled only in IDLE.
- port_num  input  PORT_W  destination port, captured on accept.
- len  input  LEN_W  payload bit count, captured on accept.
- data  input  DATA_W  payload, captured on accept.
- ser_out  output  1  serial line (registered); idles high.
- busy  output  1  high from the accept cycle until the stop bit completes.
- ser_valid  output  1  high while ser_out carries a payload bit.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, ser_out=1, busy=0, ser_valid=0, done=0.
  - All capture registers and counters clear.
  - Reset mid-frame aborts the frame immediately; the line returns high and no done pulse is generated.
- States: IDLE, START, PORT, LEN, DATA, STOP.
- IDLE:
  - ser_out=1.
  - start=1 (independent of bit_en): capture port_num/len/data, set busy=1, drive ser_out=0 on the next edge, go to START.
  - start while busy is ignored and not queued.
- General rule: outside IDLE, state, ser_out and the bit counter change only on cycles where bit_en=1. Each bit is held until the next bit_en.
- START, on bit_en: ser_out = port bit PORT_W-1, counter = PORT_W-1, go to PORT.
- PORT:
  - Sent MSB-first.
  - On bit_en: if counter=0, load ser_out with len bit LEN_W-1, counter = LEN_W-1, go to LEN; else decrement and shift out the next lower bit.
- LEN:
  - Sent MSB-first.
  - On bit_en at counter=0:
    - len=0: ser_out=1, go to STOP. DATA is skipped.
    - Otherwise: ser_out = data[0], ser_valid=1, counter=len-1, go to DATA.
- DATA:
  - Payload is sent LSB-first: data[0], data[1], ... data[len-1].
  - On bit_en at counter=0: ser_out=1, ser_valid=0, go to STOP. Otherwise decrement and output the next bit.
- STOP:
  - On bit_en: done=1 for exactly one cycle, busy=0, go to IDLE.
  - start in that same cycle is not accepted; it is accepted from the following cycle.
- Frame length is 1+PORT_W+LEN_W+len+1 bit periods; with bit_en held high, busy lasts 8+len cycles at default parameters.
- Payload bits above len-1 are never transmitted.
- Inputs are don't-care after accept.

Optional Feature:
- Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA (or LEN when len=0) and STOP.
  - Transmits one even-parity bit over the transmitted payload bits only; parity is 0 when len=0.
  - ser_valid=0 during the parity bit.
  - Frame becomes one bit longer.
- Undefined: no PARITY state and no parity logic; frame as above.

Test Plan:
- rst high 50ns then low → ser_out=1, busy=0, done=0, ser_valid=0; holding start low produces no activity.
- bit_en=1 constantly; start pulse with port_num=2'b10, len=3, data=16'h0005 → ser_out sequence 0,1,0,0,0,1,1,1,0,1,1; ser_valid high for exactly 3 cycles; done pulses once at the end; busy high for 11 cycles.
- Same frame with bit_en pulsed every 4th cycle → identical bit sequence, each bit held 4 cycles; nothing changes on non-strobe cycles.
- len=0, port_num=2'b01 → sequence 0,0,1,0,0,0,0,1; ser_valid never asserts; done pulses.
- start re-asserted mid-frame and again in the done cycle → both ignored; a third start on the cycle after done begins a new frame with start bit 0.
- rst asserted during DATA → ser_out=1, busy=0 asynchronously; no done pulse.
- With SERIAL_FRAME_TX_PARITY_EN defined, len=3, data=16'h0007 → parity bit 1 before stop; with data=16'h0005 → parity bit 0.
